// File: rtl/hilo_acc_regs_if.sv
// Request/read bundle for the HI/LO context register file.
// The master issues write/accumulate requests and selects a read channel. The slave is the register file.
interface hilo_acc_regs_if #(
  parameter int DATA_W = 32,
  parameter int CH_W   = 1
);
  logic              wr_valid;
  logic              wr_ready;
  logic [CH_W-1:0]   wr_ch;
  logic [2:0]        wr_op;
  logic [DATA_W-1:0] wr_hi;
  logic [DATA_W-1:0] wr_lo;
  logic [CH_W-1:0]   rd_ch;
  logic [DATA_W-1:0] rd_hi;
  logic [DATA_W-1:0] rd_lo;
  logic              rd_pending;
  logic              acc_busy;

  modport master (
    output wr_valid, wr_ch, wr_op, wr_hi, wr_lo, rd_ch,
    input  wr_ready, rd_hi, rd_lo, rd_pending, acc_busy
  );

  modport slave (
    input  wr_valid, wr_ch, wr_op, wr_hi, wr_lo, rd_ch,
    output wr_ready, rd_hi, rd_lo, rd_pending, acc_busy
  );
endinterface

// File: rtl/hilo_acc_regs.sv
// Per-context HI/LO register pairs with direct writes (1 cycle) and a MADD/MSUB accumulate (2 cycles).
// The unit stalls all requests while an accumulate is in flight. Reads are combinational, with no bypass.
module hilo_acc_regs #(
  parameter int DATA_W = 32,
  parameter int CH_W   = 1
) (
  input logic           clk,
  input logic           rst_n,
  hilo_acc_regs_if.slave bus
);
  localparam int NCH = 2 ** CH_W;

  localparam logic [2:0] OP_WBOTH = 3'b000;
  localparam logic [2:0] OP_WHI   = 3'b001;
  localparam logic [2:0] OP_WLO   = 3'b010;
  localparam logic [2:0] OP_MADD  = 3'b100;
  localparam logic [2:0] OP_MSUB  = 3'b101;

  typedef enum logic {IDLE, ACC} state_t;

  state_t              state;
  logic [DATA_W-1:0]   hi_q [NCH];
  logic [DATA_W-1:0]   lo_q [NCH];
  logic [CH_W-1:0]     acc_ch;
  logic                acc_sub;
  logic [2*DATA_W-1:0] acc_opnd;
  logic [2*DATA_W-1:0] acc_base;
  logic [2*DATA_W-1:0] acc_res;
  logic                accept;

  assign accept  = bus.wr_valid && bus.wr_ready;
  // Carry/borrow out of the top bit is dropped and the result wraps.
  assign acc_res = acc_sub ? (acc_base - acc_opnd) : (acc_base + acc_opnd);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      acc_ch   <= '0;
      acc_sub  <= 1'b0;
      acc_opnd <= '0;
      acc_base <= '0;
      for (int i = 0; i < NCH; i++) begin
        hi_q[i] <= '0;
        lo_q[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            case (bus.wr_op)
              OP_WBOTH: begin
                hi_q[bus.wr_ch] <= bus.wr_hi;
                lo_q[bus.wr_ch] <= bus.wr_lo;
              end
              OP_WHI: hi_q[bus.wr_ch] <= bus.wr_hi;
              OP_WLO: lo_q[bus.wr_ch] <= bus.wr_lo;
              OP_MADD, OP_MSUB: begin
                acc_ch   <= bus.wr_ch;
                acc_sub  <= bus.wr_op[0];
                acc_opnd <= {bus.wr_hi, bus.wr_lo};
                acc_base <= {hi_q[bus.wr_ch], lo_q[bus.wr_ch]};
                state    <= ACC;
              end
              default: ;
            endcase
          end
        end
        ACC: begin
          {hi_q[acc_ch], lo_q[acc_ch]} <= acc_res;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.wr_ready   = rst_n && (state == IDLE);
  assign bus.acc_busy   = (state == ACC);
  assign bus.rd_pending = (state == ACC) && (bus.rd_ch == acc_ch);
  assign bus.rd_hi      = hi_q[bus.rd_ch];
  assign bus.rd_lo      = lo_q[bus.rd_ch];
endmodule

// File: tb/tb_hilo_acc_regs.sv
// Directed bench for hilo_acc_regs. The stimulus pushes expected read-port observations into a scoreboard queue.
// A monitor process pops the queue and compares each entry against the DUT outputs.
module tb_hilo_acc_regs;
  localparam int DW = 32;

  typedef struct packed {
    logic [DW-1:0] hi;
    logic [DW-1:0] lo;
    logic          pend;
    logic          rdy;
    logic          busy;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  exp_t  exp_q[$];
  string name_q[$];
  event  chk_ev;

  hilo_acc_regs_if #(.DATA_W(DW), .CH_W(1)) bus ();

  hilo_acc_regs #(.DATA_W(DW), .CH_W(1)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Monitor: compares every queued observation against the live outputs.
  initial begin
    exp_t  e;
    string n;
    forever begin
      @(chk_ev);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        checks++;
        if ({bus.rd_hi, bus.rd_lo, bus.rd_pending, bus.wr_ready, bus.acc_busy} !== e) begin
          errors++;
          $display("FAIL %s: got hi=%h lo=%h pend=%b rdy=%b busy=%b, want hi=%h lo=%h pend=%b rdy=%b busy=%b",
                   n, bus.rd_hi, bus.rd_lo, bus.rd_pending, bus.wr_ready, bus.acc_busy,
                   e.hi, e.lo, e.pend, e.rdy, e.busy);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_rd(input string name, input logic ch, input logic [DW-1:0] hi,
                           input logic [DW-1:0] lo, input logic pend, input logic rdy,
                           input logic busy);
    exp_t e;
    bus.rd_ch = ch;
    #1;
    e.hi = hi; e.lo = lo; e.pend = pend; e.rdy = rdy; e.busy = busy;
    exp_q.push_back(e);
    name_q.push_back(name);
    ->chk_ev;
    #0;
  endtask

  task automatic drive(input logic [2:0] op, input logic ch, input logic [DW-1:0] hi,
                       input logic [DW-1:0] lo);
    bus.wr_valid = 1'b1;
    bus.wr_op    = op;
    bus.wr_ch    = ch;
    bus.wr_hi    = hi;
    bus.wr_lo    = lo;
  endtask

  // Drives one request across a single posedge and drops valid afterwards.
  task automatic issue(input logic [2:0] op, input logic ch, input logic [DW-1:0] hi,
                       input logic [DW-1:0] lo);
    drive(op, ch, hi, lo);
    tick();
    bus.wr_valid = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus.wr_valid = 1'b0;
    bus.wr_op    = 3'b000;
    bus.wr_ch    = 1'b0;
    bus.wr_hi    = '0;
    bus.wr_lo    = '0;
    bus.rd_ch    = 1'b0;

    // 1: reset, first write, read-old-then-new
    repeat (3) tick();
    expect_rd("rst_ch0", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();
    expect_rd("post_rst_ch0", 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    expect_rd("post_rst_ch1", 1'b1, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    drive(3'b000, 1'b1, 32'h1111_1111, 32'h2222_2222);
    expect_rd("wboth_old", 1'b1, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    tick();
    bus.wr_valid = 1'b0;
    expect_rd("wboth_ch1", 1'b1, 32'h1111_1111, 32'h2222_2222, 1'b0, 1'b1, 1'b0);
    expect_rd("wboth_ch0", 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);

    // 2: partial writes, issued back to back
    issue(3'b000, 1'b0, 32'h0000_0001, 32'hFFFF_FFFF);
    issue(3'b010, 1'b0, 32'hDEAD_BEEF, 32'h0000_0005);
    expect_rd("wlo", 1'b0, 32'h1, 32'h5, 1'b0, 1'b1, 1'b0);
    issue(3'b001, 1'b0, 32'h0000_000A, 32'hCAFE_F00D);
    expect_rd("whi", 1'b0, 32'hA, 32'h5, 1'b0, 1'b1, 1'b0);
    issue(3'b011, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0);
    expect_rd("nop011", 1'b0, 32'hA, 32'h5, 1'b0, 1'b1, 1'b0);
    issue(3'b110, 1'b1, 32'h1234_5678, 32'h9ABC_DEF0);
    expect_rd("nop110", 1'b1, 32'h1111_1111, 32'h2222_2222, 1'b0, 1'b1, 1'b0);

    // 3: MADD with carry from lo into hi
    issue(3'b000, 1'b0, 32'h0, 32'hFFFF_FFFF);
    issue(3'b100, 1'b0, 32'h0, 32'h1);
    expect_rd("madd_acc_ch0", 1'b0, 32'h0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1);
    expect_rd("madd_acc_ch1", 1'b1, 32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0, 1'b1);
    tick();
    expect_rd("madd_result", 1'b0, 32'h1, 32'h0, 1'b0, 1'b1, 1'b0);

    // 4: MSUB wraps below zero, MADD wraps back
    issue(3'b000, 1'b1, 32'h0, 32'h0);
    issue(3'b101, 1'b1, 32'h0, 32'h1);
    tick();
    expect_rd("msub_wrap", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0);
    issue(3'b100, 1'b1, 32'h0, 32'h1);
    tick();
    expect_rd("madd_wrap", 1'b1, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);

    // 5: reset during ACC abandons the accumulate
    issue(3'b000, 1'b1, 32'h5, 32'h6);
    issue(3'b000, 1'b0, 32'h7, 32'h7);
    issue(3'b100, 1'b0, 32'h0, 32'h3);
    rst_n = 1'b0;
    tick();
    expect_rd("rst_in_acc_ch0", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    expect_rd("rst_release_ch1", 1'b1, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    tick();
    tick();
    expect_rd("no_late_write", 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);

    // 6: held request stalls during ACC, then lands right after it
    issue(3'b000, 1'b0, 32'h0, 32'hA);
    issue(3'b100, 1'b0, 32'h2, 32'h5);
    drive(3'b000, 1'b1, 32'hAAAA_AAAA, 32'hBBBB_BBBB);
    expect_rd("held_during_acc", 1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    tick();
    expect_rd("held_after_acc", 1'b1, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    tick();
    bus.wr_valid = 1'b0;
    expect_rd("held_landed_ch1", 1'b1, 32'hAAAA_AAAA, 32'hBBBB_BBBB, 1'b0, 1'b1, 1'b0);
    expect_rd("acc_result_ch0", 1'b0, 32'h2, 32'hF, 1'b0, 1'b1, 1'b0);

    // MADD of zero still occupies two cycles
    issue(3'b100, 1'b0, 32'h0, 32'h0);
    expect_rd("madd0_busy", 1'b0, 32'h2, 32'hF, 1'b1, 1'b0, 1'b1);
    tick();
    expect_rd("madd0_result", 1'b0, 32'h2, 32'hF, 1'b0, 1'b1, 1'b0);

    #2;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
